// File: rtl/uart_tx_scheduler.sv
// Packet-level round-robin scheduler sharing one UART transmitter among NUM_REQ
// byte-stream requesters, with max packet length and inter-packet idle gap.
module uart_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [OWN_W-1:0]   last_owner_reg, last_owner_next;
  logic [CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               end_flag_reg, end_flag_next;
  logic               tx_start_reg, tx_start_next;
  logic [7:0]         tx_data_reg, tx_data_next;

  logic [7:0]         data_arr [NUM_REQ];
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               send_open;
  logic               xfer;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pick_found;
  logic [OWN_W-1:0]   pick_idx;
  logic [OWN_W-1:0]   rr_cand;

  // Only the owner ever sees ready, and only while the transmitter is free.
  assign send_open = (state_reg == SEND) && !tx_busy;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[8*gi +: 8];
      assign req_ready[gi] = send_open & grant_reg[gi];
    end
  endgenerate

  // last_owner_reg is the current owner for the whole life of a grant.
  assign sel_data  = data_arr[last_owner_reg];
  assign sel_valid = req_valid[last_owner_reg];
  assign sel_last  = req_last[last_owner_reg];
  assign xfer      = send_open && sel_valid;
  assign cnt_inc   = byte_cnt_reg + CNT_W'(1);

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    rr_cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = OWN_W'((int'(last_owner_reg) + k) % NUM_REQ);
      if (!pick_found && req_valid[rr_cand]) begin
        pick_found = 1'b1;
        pick_idx   = rr_cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_owner_reg <= OWN_W'(NUM_REQ - 1);
      byte_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      end_flag_reg   <= 1'b0;
      tx_start_reg   <= 1'b0;
      tx_data_reg    <= 8'h00;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_owner_reg <= last_owner_next;
      byte_cnt_reg   <= byte_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      end_flag_reg   <= end_flag_next;
      tx_start_reg   <= tx_start_next;
      tx_data_reg    <= tx_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_owner_next = last_owner_reg;
    byte_cnt_next   = byte_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    end_flag_next   = end_flag_reg;
    tx_start_next   = 1'b0;
    tx_data_next    = tx_data_reg;

    unique case (state_reg)
      IDLE: begin
        grant_next = '0;
        if (pick_found) begin
          grant_next      = NUM_REQ'(1) << pick_idx;
          last_owner_next = pick_idx;
          byte_cnt_next   = '0;
          end_flag_next   = 1'b0;
          state_next      = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          tx_data_next  = sel_data;
          tx_start_next = 1'b1;
          byte_cnt_next = cnt_inc;
          end_flag_next = sel_last || (cnt_inc == LEN_LAST);
          state_next    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (end_flag_reg) begin
            grant_next   = '0;
            gap_cnt_next = '0;
            state_next   = (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            state_next = SEND;
          end
        end
      end
      GAP: begin
        grant_next = '0;
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign grant    = grant_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;

endmodule
